// File: rtl/id_pkg.sv
// Shared constants for the decode stage: control-word layout, ALU op codes,
// exception-word layout and MIPS32 opcode/funct encodings.
package id_pkg;
    localparam int CB_SRC_IMM = 6;
    localparam int CB_MEM_RD  = 7;
    localparam int CB_MEM_WR  = 8;
    localparam int CB_SIZE    = 9;
    localparam int CB_SIGNED  = 11;
    localparam int CB_GPR_WE  = 12;
    localparam int CB_RD_HI   = 13;
    localparam int CB_RD_LO   = 14;
    localparam int CB_LINK    = 15;
    localparam int CB_VALID   = 16;

    localparam int IC_RI   = 2;
    localparam int IC_SYS  = 3;
    localparam int IC_BRK  = 4;
    localparam int IC_ERET = 5;
    localparam int IC_OVF  = 6;
    localparam int IC_DS   = 7;

    typedef enum logic [5:0] {
        ALU_ADD = 6'd0, ALU_ADDU = 6'd1, ALU_SUB = 6'd2, ALU_SUBU = 6'd3,
        ALU_AND = 6'd4, ALU_OR = 6'd5, ALU_XOR = 6'd6, ALU_NOR = 6'd7,
        ALU_SLT = 6'd8, ALU_SLTU = 6'd9, ALU_SLL = 6'd10, ALU_SRL = 6'd11,
        ALU_SRA = 6'd12, ALU_LUI = 6'd13, ALU_MULT = 6'd14, ALU_MULTU = 6'd15,
        ALU_DIV = 6'd16, ALU_DIVU = 6'd17, ALU_PASSA = 6'd18
    } alu_op_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_COP0 = 6'h10;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;
    localparam logic [31:0] INST_ERET = 32'h4200_0018;

    // $0 is hard-wired, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic [5:0] des, input logic [4:0] src);
        return des[5] && (des[4:0] == src) && (src != 5'd0);
    endfunction
endpackage

// File: rtl/id_fwd_mux.sv
// One GPR operand bypass: newest producer wins (EXE lane2, EXE lane1, MEM lane2, MEM lane1).
module id_fwd_mux
    import id_pkg::*;
(
    input  logic [4:0]       src,
    input  logic [1:0][5:0]  alu_des,
    input  logic [1:0][31:0] alu_res,
    input  logic [1:0][5:0]  mem_des,
    input  logic [1:0][31:0] mem_res,
    input  logic [31:0]      reg_val,
    output logic [31:0]      val
);
    always_comb begin
        val = reg_val;
        if (fwd_hit(alu_des[1], src))      val = alu_res[1];
        else if (fwd_hit(alu_des[0], src)) val = alu_res[0];
        else if (fwd_hit(mem_des[1], src)) val = mem_res[1];
        else if (fwd_hit(mem_des[0], src)) val = mem_res[0];
    end
endmodule

// File: rtl/id_stage.sv
// Decode stage of one issue lane: decode, operand bypass, branch resolution,
// load-use stall and the registered ID->EXE word.
module id_stage
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] ID_PC,
    input  logic [1:0]  IC_IF,
    input  logic [31:0] reg_rs,
    input  logic [31:0] reg_rt,
    input  logic [31:0] reg_Hi,
    input  logic [31:0] reg_Lo,
    input  logic [6:0]  alu_des_1,
    input  logic [6:0]  alu_des_2,
    input  logic [1:0]  alu_w_HiLo1,
    input  logic [1:0]  alu_w_HiLo2,
    input  logic [31:0] alu_res_1,
    input  logic [31:0] alu_res_2,
    input  logic [31:0] alu_HiLo_res_1,
    input  logic [31:0] alu_HiLo_res_2,
    input  logic [6:0]  MEM_des1,
    input  logic [6:0]  MEM_des2,
    input  logic [1:0]  MEM_w_HiLo1,
    input  logic [1:0]  MEM_w_HiLo2,
    input  logic [31:0] MEM_res_1,
    input  logic [31:0] MEM_res_2,
    input  logic [31:0] MEM_HiLo_res_1,
    input  logic [31:0] MEM_HiLo_res_2,
    output logic        branch,
    output logic        J,
    output logic        delay,
    output logic [31:0] br_target,
    output logic [4:0]  RSO,
    output logic [4:0]  RTO,
    output logic [31:0] contr_ID,
    output logic [7:0]  IC_ID,
    output logic [31:0] exe_PC,
    output logic [31:0] reg_esa,
    output logic [31:0] reg_esb,
    output logic [31:0] immed,
    output logic [6:0]  iddes,
    output logic [1:0]  ID_w_HiLo
);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [31:0] pc4, rs_val, rt_val, hi_val, lo_val;
    logic [1:0][5:0]  alu_d, mem_d;
    logic [1:0][31:0] alu_r, mem_r;

    assign {op, rs, rt, rd, sa, fn} = inst;
    assign imm16 = inst[15:0];
    assign pc4   = ID_PC + 32'd4;
    assign RSO   = rs;
    assign RTO   = rt;

    assign alu_d = {alu_des_2[5:0], alu_des_1[5:0]};
    assign alu_r = {alu_res_2, alu_res_1};
    assign mem_d = {MEM_des2[5:0], MEM_des1[5:0]};
    assign mem_r = {MEM_res_2, MEM_res_1};

    id_fwd_mux u_fwd_rs (.src(rs), .alu_des(alu_d), .alu_res(alu_r), .mem_des(mem_d),
                         .mem_res(mem_r), .reg_val(reg_rs), .val(rs_val));
    id_fwd_mux u_fwd_rt (.src(rt), .alu_des(alu_d), .alu_res(alu_r), .mem_des(mem_d),
                         .mem_res(mem_r), .reg_val(reg_rt), .val(rt_val));

    always_comb begin
        hi_val = reg_Hi;
        if (alu_w_HiLo2[1])      hi_val = alu_HiLo_res_2;
        else if (alu_w_HiLo1[1]) hi_val = alu_HiLo_res_1;
        else if (MEM_w_HiLo2[1]) hi_val = MEM_HiLo_res_2;
        else if (MEM_w_HiLo1[1]) hi_val = MEM_HiLo_res_1;
        lo_val = reg_Lo;
        if (alu_w_HiLo2[0])      lo_val = alu_HiLo_res_2;
        else if (alu_w_HiLo1[0]) lo_val = alu_HiLo_res_1;
        else if (MEM_w_HiLo2[0]) lo_val = MEM_HiLo_res_2;
        else if (MEM_w_HiLo1[0]) lo_val = MEM_HiLo_res_1;
    end

    logic [31:0] ctrl, imm_ext;
    logic [7:0]  ic;
    logic [4:0]  dreg;
    logic [1:0]  w_hilo;
    logic        we, use_rs, use_rt, is_br, cond, is_j, j_reg;

    always_comb begin
        ctrl = '0;
        ctrl[CB_VALID] = 1'b1;
        ctrl[5:0] = ALU_ADDU;
        ic = '0;
        imm_ext = {{16{imm16[15]}}, imm16};
        dreg = rt;
        we = 1'b0; w_hilo = 2'b00;
        use_rs = 1'b1; use_rt = 1'b0;
        is_br = 1'b0; cond = 1'b0; is_j = 1'b0; j_reg = 1'b0;
        case (op)
            OP_SPECIAL: begin
                dreg = rd; we = 1'b1; use_rt = 1'b1;
                case (fn)
                    FN_SLL:  begin ctrl[5:0] = ALU_SLL; ctrl[CB_SRC_IMM] = 1'b1; imm_ext = {27'b0, sa}; use_rs = 1'b0; end
                    FN_SRL:  begin ctrl[5:0] = ALU_SRL; ctrl[CB_SRC_IMM] = 1'b1; imm_ext = {27'b0, sa}; use_rs = 1'b0; end
                    FN_SRA:  begin ctrl[5:0] = ALU_SRA; ctrl[CB_SRC_IMM] = 1'b1; imm_ext = {27'b0, sa}; use_rs = 1'b0; end
                    FN_SLLV: ctrl[5:0] = ALU_SLL;
                    FN_SRLV: ctrl[5:0] = ALU_SRL;
                    FN_SRAV: ctrl[5:0] = ALU_SRA;
                    FN_JR:   begin we = 1'b0; use_rt = 1'b0; is_j = 1'b1; j_reg = 1'b1; end
                    FN_JALR: begin use_rt = 1'b0; is_j = 1'b1; j_reg = 1'b1; ctrl[CB_LINK] = 1'b1; end
                    FN_SYSCALL: begin we = 1'b0; use_rs = 1'b0; use_rt = 1'b0; ic[IC_SYS] = 1'b1; end
                    FN_BREAK:   begin we = 1'b0; use_rs = 1'b0; use_rt = 1'b0; ic[IC_BRK] = 1'b1; end
                    FN_MFHI: begin ctrl[5:0] = ALU_PASSA; ctrl[CB_RD_HI] = 1'b1; use_rs = 1'b0; use_rt = 1'b0; end
                    FN_MFLO: begin ctrl[5:0] = ALU_PASSA; ctrl[CB_RD_LO] = 1'b1; use_rs = 1'b0; use_rt = 1'b0; end
                    FN_MTHI: begin ctrl[5:0] = ALU_PASSA; we = 1'b0; use_rt = 1'b0; w_hilo = 2'b10; end
                    FN_MTLO: begin ctrl[5:0] = ALU_PASSA; we = 1'b0; use_rt = 1'b0; w_hilo = 2'b01; end
                    FN_MULT:  begin ctrl[5:0] = ALU_MULT;  we = 1'b0; w_hilo = 2'b11; end
                    FN_MULTU: begin ctrl[5:0] = ALU_MULTU; we = 1'b0; w_hilo = 2'b11; end
                    FN_DIV:   begin ctrl[5:0] = ALU_DIV;   we = 1'b0; w_hilo = 2'b11; end
                    FN_DIVU:  begin ctrl[5:0] = ALU_DIVU;  we = 1'b0; w_hilo = 2'b11; end
                    FN_ADD:  begin ctrl[5:0] = ALU_ADD; ic[IC_OVF] = 1'b1; end
                    FN_ADDU: ctrl[5:0] = ALU_ADDU;
                    FN_SUB:  begin ctrl[5:0] = ALU_SUB; ic[IC_OVF] = 1'b1; end
                    FN_SUBU: ctrl[5:0] = ALU_SUBU;
                    FN_AND:  ctrl[5:0] = ALU_AND;
                    FN_OR:   ctrl[5:0] = ALU_OR;
                    FN_XOR:  ctrl[5:0] = ALU_XOR;
                    FN_NOR:  ctrl[5:0] = ALU_NOR;
                    FN_SLT:  ctrl[5:0] = ALU_SLT;
                    FN_SLTU: ctrl[5:0] = ALU_SLTU;
                    default: begin we = 1'b0; use_rs = 1'b0; use_rt = 1'b0; ic[IC_RI] = 1'b1; end
                endcase
            end
            OP_REGIMM: begin
                is_br = 1'b1; dreg = 5'd31;
                case (rt)
                    RI_BLTZ:   cond = rs_val[31];
                    RI_BGEZ:   cond = ~rs_val[31];
                    RI_BLTZAL: begin cond = rs_val[31];  we = 1'b1; ctrl[CB_LINK] = 1'b1; end
                    RI_BGEZAL: begin cond = ~rs_val[31]; we = 1'b1; ctrl[CB_LINK] = 1'b1; end
                    default:   begin is_br = 1'b0; use_rs = 1'b0; ic[IC_RI] = 1'b1; end
                endcase
            end
            OP_J:    begin is_j = 1'b1; use_rs = 1'b0; end
            OP_JAL:  begin is_j = 1'b1; use_rs = 1'b0; we = 1'b1; dreg = 5'd31; ctrl[CB_LINK] = 1'b1; end
            OP_BEQ:  begin is_br = 1'b1; use_rt = 1'b1; cond = (rs_val == rt_val); end
            OP_BNE:  begin is_br = 1'b1; use_rt = 1'b1; cond = (rs_val != rt_val); end
            OP_BLEZ: begin is_br = 1'b1; cond = rs_val[31] || (rs_val == 32'd0); end
            OP_BGTZ: begin is_br = 1'b1; cond = !rs_val[31] && (rs_val != 32'd0); end
            OP_ADDI:  begin ctrl[5:0] = ALU_ADD;  ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; ic[IC_OVF] = 1'b1; end
            OP_ADDIU: begin ctrl[5:0] = ALU_ADDU; ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; end
            OP_SLTI:  begin ctrl[5:0] = ALU_SLT;  ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; end
            OP_SLTIU: begin ctrl[5:0] = ALU_SLTU; ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; end
            OP_ANDI:  begin ctrl[5:0] = ALU_AND;  ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; imm_ext = {16'b0, imm16}; end
            OP_ORI:   begin ctrl[5:0] = ALU_OR;   ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; imm_ext = {16'b0, imm16}; end
            OP_XORI:  begin ctrl[5:0] = ALU_XOR;  ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; imm_ext = {16'b0, imm16}; end
            OP_LUI:   begin ctrl[5:0] = ALU_LUI;  ctrl[CB_SRC_IMM] = 1'b1; we = 1'b1; use_rs = 1'b0;
                            imm_ext = {imm16, 16'b0}; end
            OP_COP0: begin
                use_rs = 1'b0;
                if (inst == INST_ERET) ic[IC_ERET] = 1'b1;
                else                   ic[IC_RI] = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl[CB_SRC_IMM] = 1'b1; ctrl[CB_MEM_RD] = 1'b1; we = 1'b1;
                ctrl[CB_SIZE +: 2] = (op == OP_LW) ? 2'd2 : {1'b0, op[0]};
                ctrl[CB_SIGNED] = !op[2];
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl[CB_SRC_IMM] = 1'b1; ctrl[CB_MEM_WR] = 1'b1; use_rt = 1'b1;
                ctrl[CB_SIZE +: 2] = (op == OP_SW) ? 2'd2 : {1'b0, op[0]};
            end
            default: begin use_rs = 1'b0; ic[IC_RI] = 1'b1; end
        endcase
        // A write to $0 is architecturally void, which also makes inst==0 a pure NOP.
        if (dreg == 5'd0) we = 1'b0;
        ctrl[CB_GPR_WE] = we;
        ic[1:0] = IC_IF;
    end

    logic stall, in_ds;
    assign stall = (use_rs && rs != 5'd0 && ((alu_des_1[6] && alu_des_1[4:0] == rs) ||
                                             (alu_des_2[6] && alu_des_2[4:0] == rs))) ||
                   (use_rt && rt != 5'd0 && ((alu_des_1[6] && alu_des_1[4:0] == rt) ||
                                             (alu_des_2[6] && alu_des_2[4:0] == rt)));
    assign delay  = stall;
    assign branch = is_br && cond && !stall;
    assign J      = is_j && !stall;

    always_comb begin
        if (j_reg)                         br_target = rs_val;
        else if (op == OP_J || op == OP_JAL) br_target = {pc4[31:28], inst[25:0], 2'b00};
        else                               br_target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || stall) begin
            contr_ID <= '0; IC_ID <= '0; exe_PC <= '0; reg_esa <= '0; reg_esb <= '0;
            immed <= '0; iddes <= '0; ID_w_HiLo <= '0;
            if (reset) in_ds <= 1'b0;
        end else begin
            contr_ID  <= ctrl;
            IC_ID     <= {in_ds, ic[6:0]};
            exe_PC    <= ID_PC;
            reg_esa   <= ctrl[CB_RD_HI] ? hi_val : ctrl[CB_RD_LO] ? lo_val : rs_val;
            reg_esb   <= rt_val;
            immed     <= imm_ext;
            iddes     <= we ? {ctrl[CB_MEM_RD], 1'b1, dreg} : 7'd0;
            ID_w_HiLo <= w_hilo;
            in_ds     <= is_br || is_j;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed checks of the decode stage with hand-computed expected values.
module tb_id_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] inst, ID_PC, reg_rs, reg_rt, reg_Hi, reg_Lo;
    logic [1:0]  IC_IF;
    logic [6:0]  alu_des_1, alu_des_2, MEM_des1, MEM_des2;
    logic [1:0]  alu_w_HiLo1, alu_w_HiLo2, MEM_w_HiLo1, MEM_w_HiLo2;
    logic [31:0] alu_res_1, alu_res_2, alu_HiLo_res_1, alu_HiLo_res_2;
    logic [31:0] MEM_res_1, MEM_res_2, MEM_HiLo_res_1, MEM_HiLo_res_2;
    logic        branch, J, delay;
    logic [31:0] br_target, contr_ID, exe_PC, reg_esa, reg_esb, immed;
    logic [4:0]  RSO, RTO;
    logic [7:0]  IC_ID;
    logic [6:0]  iddes;
    logic [1:0]  ID_w_HiLo;
    int n_chk = 0, n_err = 0;

    id_stage dut (
        .clk(clk), .reset(reset), .inst(inst), .ID_PC(ID_PC), .IC_IF(IC_IF),
        .reg_rs(reg_rs), .reg_rt(reg_rt), .reg_Hi(reg_Hi), .reg_Lo(reg_Lo),
        .alu_des_1(alu_des_1), .alu_des_2(alu_des_2), .alu_w_HiLo1(alu_w_HiLo1), .alu_w_HiLo2(alu_w_HiLo2),
        .alu_res_1(alu_res_1), .alu_res_2(alu_res_2), .alu_HiLo_res_1(alu_HiLo_res_1), .alu_HiLo_res_2(alu_HiLo_res_2),
        .MEM_des1(MEM_des1), .MEM_des2(MEM_des2), .MEM_w_HiLo1(MEM_w_HiLo1), .MEM_w_HiLo2(MEM_w_HiLo2),
        .MEM_res_1(MEM_res_1), .MEM_res_2(MEM_res_2), .MEM_HiLo_res_1(MEM_HiLo_res_1), .MEM_HiLo_res_2(MEM_HiLo_res_2),
        .branch(branch), .J(J), .delay(delay), .br_target(br_target), .RSO(RSO), .RTO(RTO),
        .contr_ID(contr_ID), .IC_ID(IC_ID), .exe_PC(exe_PC), .reg_esa(reg_esa), .reg_esb(reg_esb),
        .immed(immed), .iddes(iddes), .ID_w_HiLo(ID_w_HiLo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_fwd();
        alu_des_1 = '0; alu_des_2 = '0; MEM_des1 = '0; MEM_des2 = '0;
        alu_w_HiLo1 = '0; alu_w_HiLo2 = '0; MEM_w_HiLo1 = '0; MEM_w_HiLo2 = '0;
        alu_res_1 = '0; alu_res_2 = '0; alu_HiLo_res_1 = '0; alu_HiLo_res_2 = '0;
        MEM_res_1 = '0; MEM_res_2 = '0; MEM_HiLo_res_1 = '0; MEM_HiLo_res_2 = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Apply an instruction with its PC and regfile reads, then settle.
    task automatic apply(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        inst = i; ID_PC = pc; reg_rs = a; reg_rt = b; #1;
    endtask

    initial begin
        inst = '0; ID_PC = '0; IC_IF = '0; reg_rs = '0; reg_rt = '0;
        reg_Hi = 32'h1111; reg_Lo = 32'h2222;
        clr_fwd();
        step(); step();
        chk("rst_contr", contr_ID, 0); chk("rst_ic", {24'd0, IC_ID}, 0);
        chk("rst_esa", reg_esa, 0); chk("rst_iddes", {25'd0, iddes}, 0);
        reset = 1'b0;

        // ADDIU $2,$1,-1
        apply(32'h2422FFFF, 32'h100, 5, 0);
        chk("addiu_rso", {27'd0, RSO}, 1); chk("addiu_rto", {27'd0, RTO}, 2);
        chk("addiu_delay", {31'd0, delay}, 0);
        step();
        chk("addiu_contr", contr_ID, 32'h11041); chk("addiu_esa", reg_esa, 5);
        chk("addiu_imm", immed, 32'hFFFFFFFF); chk("addiu_iddes", {25'd0, iddes}, 32'h22);
        chk("addiu_pc", exe_PC, 32'h100); chk("addiu_ic", {24'd0, IC_ID}, 0);

        // ADDU $3,$1,$2 forwarding priority
        apply(32'h00221821, 32'h104, 1, 2);
        alu_des_2 = 7'h21; alu_res_2 = 9; alu_des_1 = 7'h21; alu_res_1 = 7;
        step();
        chk("fwd_alu2", reg_esa, 9); chk("fwd_rt_reg", reg_esb, 2);
        chk("addu_contr", contr_ID, 32'h11001); chk("addu_iddes", {25'd0, iddes}, 32'h23);
        alu_des_2 = '0; step();
        chk("fwd_alu1", reg_esa, 7);
        clr_fwd(); MEM_des1 = 7'h21; MEM_res_1 = 32'h33; MEM_des2 = 7'h21; MEM_res_2 = 32'h44;
        step();
        chk("fwd_mem2", reg_esa, 32'h44);
        MEM_des2 = 7'h22; MEM_res_2 = 32'h55; step();
        chk("fwd_mem1", reg_esa, 32'h33); chk("fwd_rt_mem2", reg_esb, 32'h55);
        clr_fwd(); alu_des_1 = 7'h01; alu_res_1 = 32'h77; step();
        chk("fwd_no_we", reg_esa, 1);

        // src $0 never forwarded, never stalls
        clr_fwd(); apply(32'h00021821, 32'h108, 0, 2);
        alu_des_2 = 7'h20; alu_res_2 = 32'h99; alu_des_1 = 7'h60; #1;
        chk("zero_nostall", {31'd0, delay}, 0);
        step();
        chk("zero_nofwd", reg_esa, 0);

        // Load-use: LW $4 in EXE, ADDU $5,$4,$0 in ID
        clr_fwd(); apply(32'h00802821, 32'h10C, 4, 0);
        alu_des_1 = 7'h64; #1;
        chk("lu_delay", {31'd0, delay}, 1);
        step();
        chk("lu_bubble_contr", contr_ID, 0); chk("lu_bubble_iddes", {25'd0, iddes}, 0);
        chk("lu_bubble_pc", exe_PC, 0);
        alu_des_1 = 7'h00; MEM_des1 = 7'h64; MEM_res_1 = 32'h42; #1;
        chk("lu_mem_nostall", {31'd0, delay}, 0);
        step();
        chk("lu_mem_fwd", reg_esa, 32'h42);

        // LW $4,8($1)
        clr_fwd(); apply(32'h8C240008, 32'h110, 3, 0); step();
        chk("lw_contr", contr_ID, 32'h11CC1); chk("lw_iddes", {25'd0, iddes}, 32'h64);
        chk("lw_imm", immed, 8);

        // BEQ $1,$1,+4 at 0x100, then delay-slot flag
        apply(32'h10210004, 32'h100, 5, 5);
        chk("beq_taken", {31'd0, branch}, 1); chk("beq_tgt", br_target, 32'h114);
        chk("beq_j", {31'd0, J}, 0);
        step();
        chk("beq_ic", {24'd0, IC_ID}, 0);
        apply(32'h0, 32'h104, 0, 0); step();
        chk("ds_ic", {24'd0, IC_ID}, 32'h80); chk("nop_iddes", {25'd0, iddes}, 0);
        chk("nop_we", {31'd0, contr_ID[12]}, 0); chk("nop_valid", {31'd0, contr_ID[16]}, 1);
        step();
        chk("ds_clear", {24'd0, IC_ID}, 0);

        // BNE $1,$2: equal via forwarded rt -> not taken
        apply(32'h14220004, 32'h200, 5, 6);
        chk("bne_taken", {31'd0, branch}, 1);
        alu_des_1 = 7'h22; alu_res_1 = 5; #1;
        chk("bne_fwd_nt", {31'd0, branch}, 0);
        step(); clr_fwd();

        // BGEZAL $1
        apply(32'h04310003, 32'h200, 32'h80000000, 0);
        chk("bgezal_nt", {31'd0, branch}, 0);
        reg_rs = 1; #1;
        chk("bgezal_t", {31'd0, branch}, 1); chk("bgezal_tgt", br_target, 32'h210);
        step();
        chk("bgezal_contr", contr_ID, 32'h19001); chk("bgezal_iddes", {25'd0, iddes}, 32'h3F);
        chk("bgezal_ds", {24'd0, IC_ID}, 32'h80);

        // J and JR
        apply(32'h08000040, 32'h100, 0, 0);
        chk("j_j", {31'd0, J}, 1); chk("j_tgt", br_target, 32'h100); chk("j_br", {31'd0, branch}, 0);
        step();
        apply(32'h00200008, 32'h300, 32'h2000, 0);
        chk("jr_tgt", br_target, 32'h2000);
        alu_des_2 = 7'h21; alu_res_2 = 32'h3000; #1;
        chk("jr_fwd_tgt", br_target, 32'h3000); chk("jr_j", {31'd0, J}, 1);
        step(); clr_fwd();
        apply(32'h0, 32'h304, 0, 0); step();

        // HI/LO
        apply(32'h00003010, 32'h400, 0, 0);
        alu_w_HiLo1 = 2'b10; alu_HiLo_res_1 = 32'hABCD; MEM_w_HiLo2 = 2'b10; MEM_HiLo_res_2 = 32'h2222;
        step();
        chk("mfhi_esa", reg_esa, 32'hABCD); chk("mfhi_contr", contr_ID, 32'h13012);
        chk("mfhi_iddes", {25'd0, iddes}, 32'h26);
        clr_fwd(); apply(32'h00003012, 32'h404, 0, 0);
        MEM_w_HiLo1 = 2'b01; MEM_HiLo_res_1 = 32'h5555; step();
        chk("mflo_esa", reg_esa, 32'h5555);
        clr_fwd(); apply(32'h00003012, 32'h408, 0, 0); step();
        chk("mflo_reg", reg_esa, 32'h2222);
        apply(32'h00200011, 32'h40C, 7, 0); step();
        chk("mthi_w", {30'd0, ID_w_HiLo}, 2); chk("mthi_iddes", {25'd0, iddes}, 0);
        apply(32'h00220018, 32'h410, 7, 8); step();
        chk("mult_w", {30'd0, ID_w_HiLo}, 3);

        // Immediates and exceptions
        apply(32'h3C011234, 32'h500, 0, 0); step();
        chk("lui_imm", immed, 32'h12340000); chk("lui_iddes", {25'd0, iddes}, 32'h21);
        apply(32'h34218000, 32'h504, 0, 0); step();
        chk("ori_imm", immed, 32'h00008000);
        apply(32'h00011140, 32'h508, 0, 0); step();
        chk("sll_imm", immed, 5);
        apply(32'hFC000000, 32'h50C, 0, 0); step();
        chk("ri_ic", {24'd0, IC_ID}, 32'h04); chk("ri_iddes", {25'd0, iddes}, 0);
        IC_IF = 2'b01; step();
        chk("ri_icif", {24'd0, IC_ID}, 32'h05);
        IC_IF = 2'b00; apply(32'h0000000C, 32'h510, 0, 0); step();
        chk("sys_ic", {24'd0, IC_ID}, 32'h08);
        apply(32'h00221820, 32'h514, 0, 0); step();
        chk("add_ovf", {24'd0, IC_ID}, 32'h40);

        // Asynchronous reset mid-stream, after a branch
        apply(32'h10210004, 32'h600, 5, 5); step();
        #3 reset = 1'b1; #1;
        chk("arst_contr", contr_ID, 0); chk("arst_pc", exe_PC, 0);
        chk("arst_esa", reg_esa, 0); chk("arst_imm", immed, 0);
        #1 reset = 1'b0;
        apply(32'h0, 32'h604, 0, 0); step();
        chk("arst_ds", {24'd0, IC_ID}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
